// File: rtl/coh_ctrl_rr.sv
// Bus-snooping coherence controller and single-port RAM arbiter for CPUS cores.
// Coherence beats writeback beats ifetch; each class is round-robin; block moves are WORDS long.
module coh_ctrl_rr #(
   parameter int unsigned CPUS  = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned WORDS = 2
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [CPUS-1:0]     iREN,
   input  logic [CPUS*AW-1:0]  iaddr,
   output logic [CPUS-1:0]     iwait,
   output logic [CPUS*DW-1:0]  iload,
   input  logic [CPUS-1:0]     dREN,
   input  logic [CPUS-1:0]     dWEN,
   input  logic [CPUS*AW-1:0]  daddr,
   input  logic [CPUS*DW-1:0]  dstore,
   output logic [CPUS-1:0]     dwait,
   output logic [CPUS*DW-1:0]  dload,
   input  logic [CPUS-1:0]     cctrans,
   input  logic [CPUS-1:0]     ccwrite,
   output logic [CPUS-1:0]     ccwait,
   output logic [CPUS-1:0]     ccinv,
   output logic [CPUS*AW-1:0]  ccsnoopaddr,
   output logic                ramREN,
   output logic                ramWEN,
   output logic [AW-1:0]       ramaddr,
   output logic [DW-1:0]       ramstore,
   input  logic [DW-1:0]       ramload,
   input  logic [1:0]          ramstate
);

   localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [1:0]    RAM_ACCESS = 2'd2;
   localparam logic [IW-1:0] PTR_RST    = IW'(CPUS - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WORDS - 1);

   typedef enum logic [2:0] {IDLE, SNOOP, RESP, C2C, RAMRD} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] req_q, req_d;
   logic [IW-1:0] sup_q, sup_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] ptr_coh_q, ptr_coh_d;
   logic [IW-1:0] ptr_wb_q, ptr_wb_d;
   logic [IW-1:0] ptr_if_q, ptr_if_d;

   logic [AW-1:0] iaddr_a  [CPUS];
   logic [AW-1:0] daddr_a  [CPUS];
   logic [DW-1:0] dstore_a [CPUS];
   logic [DW-1:0] iload_a  [CPUS];
   logic [DW-1:0] dload_a  [CPUS];
   logic [AW-1:0] snaddr_a [CPUS];

   logic            access;
   logic [IW-1:0]   coh_win, wb_win, if_win, sup_pick;
   logic [CPUS-1:0] req_oh, sup_cand;
   logic            sup_found;

   // Fills always go through the coherence path, so dREN carries no extra information.
   logic unused_dren;
   assign unused_dren = ^dREN;

   for (genvar k = 0; k < CPUS; k++) begin : g_bus
      assign iaddr_a[k]                  = iaddr[k*AW +: AW];
      assign daddr_a[k]                  = daddr[k*AW +: AW];
      assign dstore_a[k]                 = dstore[k*DW +: DW];
      assign iload[k*DW +: DW]           = iload_a[k];
      assign dload[k*DW +: DW]           = dload_a[k];
      assign ccsnoopaddr[k*AW +: AW]     = snaddr_a[k];
   end

   // First set bit of req found searching upward from ptr+1, wrapping modulo CPUS.
   function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                             input logic [IW-1:0]   ptr);
      logic [IW-1:0] pick;
      logic          found;
      int unsigned   idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= CPUS; k++) begin
         idx = (32'(ptr) + k) % CPUS;
         if (!found && req[IW'(idx)]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign access    = (ramstate == RAM_ACCESS);
   assign coh_win   = rr_pick(cctrans, ptr_coh_q);
   assign wb_win    = rr_pick(dWEN, ptr_wb_q);
   assign if_win    = rr_pick(iREN, ptr_if_q);
   assign req_oh    = CPUS'(1) << req_q;
   assign sup_cand  = ccwrite & ~req_oh;
   assign sup_found = |sup_cand;
   assign sup_pick  = rr_pick(sup_cand, req_q);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      sup_d     = sup_q;
      cnt_d     = cnt_q;
      ptr_coh_d = ptr_coh_q;
      ptr_wb_d  = ptr_wb_q;
      ptr_if_d  = ptr_if_q;
      iwait     = '1;
      dwait     = '1;
      ccwait    = '0;
      ccinv     = '0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      for (int unsigned k = 0; k < CPUS; k++) begin
         iload_a[k]  = '0;
         dload_a[k]  = '0;
         snaddr_a[k] = '0;
      end

      case (state_q)
         IDLE: begin
            if (|cctrans) begin
               req_d     = coh_win;
               ptr_coh_d = coh_win;
               state_d   = SNOOP;
            end else if (|dWEN) begin
               ramWEN   = 1'b1;
               ramaddr  = daddr_a[wb_win];
               ramstore = dstore_a[wb_win];
               if (access) begin
                  dwait[wb_win] = 1'b0;
                  ptr_wb_d      = wb_win;
               end
            end else if (|iREN) begin
               ramREN           = 1'b1;
               ramaddr          = iaddr_a[if_win];
               iload_a[if_win]  = ramload;
               if (access) begin
                  iwait[if_win] = 1'b0;
                  ptr_if_d      = if_win;
               end
            end
         end

         default: begin
            // A requester that withdraws abandons the block; nothing is driven this cycle.
            if (!cctrans[req_q]) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               ccwait = ~req_oh;
               ccinv  = ccwrite[req_q] ? ~req_oh : '0;
               for (int unsigned k = 0; k < CPUS; k++) begin
                  if (IW'(k) != req_q) snaddr_a[k] = daddr_a[req_q];
               end

               case (state_q)
                  SNOOP: state_d = RESP;
                  RESP: begin
                     sup_d   = sup_pick;
                     cnt_d   = '0;
                     state_d = sup_found ? C2C : RAMRD;
                  end
                  C2C: begin
                     ramWEN         = 1'b1;
                     ramaddr        = daddr_a[sup_q];
                     ramstore       = dstore_a[sup_q];
                     dload_a[req_q] = dstore_a[sup_q];
                     if (access) begin
                        dwait[req_q] = 1'b0;
                        dwait[sup_q] = 1'b0;
                     end
                  end
                  RAMRD: begin
                     ramREN         = 1'b1;
                     ramaddr        = daddr_a[req_q];
                     dload_a[req_q] = ramload;
                     if (access) dwait[req_q] = 1'b0;
                  end
                  default: ;
               endcase

               if ((state_q == C2C || state_q == RAMRD) && access) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         req_q     <= '0;
         sup_q     <= '0;
         cnt_q     <= '0;
         ptr_coh_q <= PTR_RST;
         ptr_wb_q  <= PTR_RST;
         ptr_if_q  <= PTR_RST;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         sup_q     <= sup_d;
         cnt_q     <= cnt_d;
         ptr_coh_q <= ptr_coh_d;
         ptr_wb_q  <= ptr_wb_d;
         ptr_if_q  <= ptr_if_d;
      end
   end

endmodule
